sd_cmd_deserializer: RTL and testbench

- Receive stage for CMD-line responses. Sits between the CMD pad and the command controller.
- When the controller asserts enable_deserializer, the block hunts for a start bit on cmd_pin and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response MSB-first.
- It checks CRC7 and framing, then presents the frame on response with deserialize_complete.
- The controller consumes response and deserialize_complete to raise response_ready.

---
 rtl/sd_cmd_deserializer.sv | 160 ++++++++++++++++
 tb/tb_sd_cmd_deserializer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_deserializer.sv
// CMD-line response receiver: hunts for the start bit, shifts in a 48- or
// 136-bit response MSB-first, checks CRC7 and framing, then holds the frame
// on response with deserialize_complete until the controller drops enable.
module sd_cmd_deserializer #(
    parameter int SHORT_LEN = 48,
    parameter int LONG_LEN  = 136,
    parameter int CNT_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                reset_deserializer,
    input  logic                enable_deserializer,
    input  logic                long_response,
    input  logic                crc_check_disable,
    input  logic                cmd_pin,
    output logic [LONG_LEN-1:0] response,
    output logic                deserialize_complete,
    output logic                crc_error,
    output logic                framing_error
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        CHECK,
        DONE
    } state_t;

    // Counter value at which the final (end) bit is shifted in.
    localparam logic [CNT_W-1:0] SHORT_LAST   = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_LEN - 1);
    // CRC window in counter terms: counter c carries frame bit len-1-c.
    // Short frames cover everything above the CRC byte; long frames skip the
    // leading start/tx/reserved byte.
    localparam logic [CNT_W-1:0] SHORT_CRC_LO = CNT_W'(0);
    localparam logic [CNT_W-1:0] SHORT_CRC_HI = CNT_W'(SHORT_LEN - 8);
    localparam logic [CNT_W-1:0] LONG_CRC_LO  = CNT_W'(8);
    localparam logic [CNT_W-1:0] LONG_CRC_HI  = CNT_W'(LONG_LEN - 8);

    state_t              state;
    logic [CNT_W-1:0]    counter;
    logic [6:0]          crc;
    logic [LONG_LEN-1:0] shift_reg;
    logic                long_lat;
    logic                crc_dis_lat;

    logic [CNT_W-1:0]    last_idx;
    logic [CNT_W-1:0]    crc_lo;
    logic [CNT_W-1:0]    crc_hi;
    logic                crc_en;
    logic                tx_bit;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Frame-length dependent limits and the transmission bit position.
    always_comb begin
        last_idx = long_lat ? LONG_LAST : SHORT_LAST;
        crc_lo   = long_lat ? LONG_CRC_LO : SHORT_CRC_LO;
        crc_hi   = long_lat ? LONG_CRC_HI : SHORT_CRC_HI;
        crc_en   = (counter >= crc_lo) && (counter < crc_hi);
        tx_bit   = long_lat ? shift_reg[LONG_LEN-2] : shift_reg[SHORT_LEN-2];
    end

    // Receive FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            counter              <= '0;
            crc                  <= '0;
            shift_reg            <= '0;
            long_lat             <= 1'b0;
            crc_dis_lat          <= 1'b0;
            response             <= '0;
            deserialize_complete <= 1'b0;
            crc_error            <= 1'b0;
            framing_error        <= 1'b0;
        end else if (reset_deserializer) begin
            state                <= IDLE;
            counter              <= '0;
            crc                  <= '0;
            shift_reg            <= '0;
            long_lat             <= 1'b0;
            crc_dis_lat          <= 1'b0;
            response             <= '0;
            deserialize_complete <= 1'b0;
            crc_error            <= 1'b0;
            framing_error        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_deserializer) begin
                        long_lat             <= long_response;
                        crc_dis_lat          <= crc_check_disable;
                        // Clearing the shift register here is what leaves
                        // [135:48] zero after a short frame.
                        shift_reg            <= '0;
                        counter              <= '0;
                        crc                  <= '0;
                        response             <= '0;
                        deserialize_complete <= 1'b0;
                        crc_error            <= 1'b0;
                        framing_error        <= 1'b0;
                        state                <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (!enable_deserializer) begin
                        state <= IDLE;
                    end else if (!cmd_pin) begin
                        // A zero start bit leaves the CRC at its zero init.
                        shift_reg <= {shift_reg[LONG_LEN-2:0], 1'b0};
                        counter   <= CNT_W'(1);
                        crc       <= '0;
                        state     <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (!enable_deserializer) begin
                        state <= IDLE;
                    end else begin
                        shift_reg <= {shift_reg[LONG_LEN-2:0], cmd_pin};
                        counter   <= counter + CNT_W'(1);
                        if (crc_en) begin
                            crc <= crc7_next(crc, cmd_pin);
                        end
                        if (counter == last_idx) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    response      <= shift_reg;
                    crc_error     <= (crc != shift_reg[7:1]) && !crc_dis_lat;
                    framing_error <= tx_bit || !shift_reg[0];
                    state         <= DONE;
                end
                DONE: begin
                    // Holding here until enable drops prevents re-arming on a
                    // level enable that the controller has not yet released.
                    if (!enable_deserializer) begin
                        deserialize_complete <= 1'b0;
                        crc_error            <= 1'b0;
                        framing_error        <= 1'b0;
                        state                <= IDLE;
                    end else begin
                        deserialize_complete <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_deserializer.sv
// Directed bench for sd_cmd_deserializer: valid, corrupted, framing and long
// frames, abort, both resets, and hold/re-arm in DONE.
module tb_sd_cmd_deserializer;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         reset_deserializer = 1'b0;
    logic         enable_deserializer = 1'b0;
    logic         long_response = 1'b0;
    logic         crc_check_disable = 1'b0;
    logic         cmd_pin = 1'b1;
    logic [135:0] response;
    logic         deserialize_complete;
    logic         crc_error;
    logic         framing_error;

    int checks   = 0;
    int failures = 0;

    // Completion samples: two negedges after the end bit must read 0, third 1.
    logic lat0, lat1, lat2, early;

    localparam logic [135:0] R7      = 136'h08000001AA13;
    localparam logic [135:0] R7_BAD  = 136'h08000001AA15;
    localparam logic [135:0] R7_TX   = 136'h48000001AA87;
    localparam logic [135:0] R7_END  = 136'h08000001AA12;
    localparam logic [119:0] CID     = 120'h0353_4453_4430_3280_1234_5678_9A01_23;

    sd_cmd_deserializer #(
        .SHORT_LEN(48),
        .LONG_LEN (136),
        .CNT_W    (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .reset_deserializer  (reset_deserializer),
        .enable_deserializer (enable_deserializer),
        .long_response       (long_response),
        .crc_check_disable   (crc_check_disable),
        .cmd_pin             (cmd_pin),
        .response            (response),
        .deserialize_complete(deserialize_complete),
        .crc_error           (crc_error),
        .framing_error       (framing_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference CRC7 (x^7+x^3+1, init 0) over a 120-bit CID, MSB first.
    function automatic logic [6:0] crc7_ref(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 119; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Raise enable, idle high for idle_n cycles, then shift out len bits.
    // The mode inputs are flipped after the latch point to show they are ignored.
    task automatic drive_frame(input logic [135:0] f, input int len,
                               input logic lng, input logic dis, input int idle_n);
        @(negedge clock);
        long_response       = lng;
        crc_check_disable   = dis;
        enable_deserializer = 1'b1;
        cmd_pin             = 1'b1;
        for (int k = 0; k < idle_n; k++) begin
            @(negedge clock);
            if (k == 0) begin
                long_response     = ~lng;
                crc_check_disable = ~dis;
            end
        end
        early = 1'b0;
        for (int i = len - 1; i >= 0; i--) begin
            @(negedge clock);
            if (deserialize_complete) early = 1'b1;
            cmd_pin = f[i];
        end
        @(negedge clock);
        cmd_pin = 1'b1;
        lat0 = deserialize_complete;
        @(negedge clock);
        lat1 = deserialize_complete;
        @(negedge clock);
        lat2 = deserialize_complete;
    endtask

    task automatic drop_enable();
        @(negedge clock);
        enable_deserializer = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (deserialize_complete !== 1'b0 || crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got complete=%b crc=%b frm=%b, want 0 0 0",
                     deserialize_complete, crc_error, framing_error);
        end
        checks++;
        if (response !== 136'h0) begin
            failures++;
            $display("FAIL reset_response: got %h, want 0", response);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (deserialize_complete !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got complete=%b, want 0", deserialize_complete);
        end
    endtask

    task automatic test_r7();
        drive_frame(R7, 48, 1'b0, 1'b0, 16);
        checks++;
        if ({early, lat0, lat1, lat2} !== 4'b0001) begin
            failures++;
            $display("FAIL r7_latency: got early,l0,l1,l2=%b, want 0001", {early, lat0, lat1, lat2});
        end
        checks++;
        if (response !== R7) begin
            failures++;
            $display("FAIL r7_response: got %h, want %h", response, R7);
        end
        checks++;
        if (crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL r7_flags: got crc=%b frm=%b, want 0 0", crc_error, framing_error);
        end
        drop_enable();
        checks++;
        if (deserialize_complete !== 1'b0 || response !== R7) begin
            failures++;
            $display("FAIL r7_release: got complete=%b resp=%h, want 0 %h",
                     deserialize_complete, response, R7);
        end
    endtask

    task automatic test_crc();
        drive_frame(R7_BAD, 48, 1'b0, 1'b0, 4);
        checks++;
        if (lat2 !== 1'b1 || crc_error !== 1'b1 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL crc_bad: got complete=%b crc=%b frm=%b, want 1 1 0",
                     lat2, crc_error, framing_error);
        end
        drop_enable();
        drive_frame(R7_BAD, 48, 1'b0, 1'b1, 4);
        checks++;
        if (lat2 !== 1'b1 || crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL crc_disabled: got complete=%b crc=%b frm=%b, want 1 0 0",
                     lat2, crc_error, framing_error);
        end
        drop_enable();
    endtask

    task automatic test_framing();
        drive_frame(R7_TX, 48, 1'b0, 1'b0, 3);
        checks++;
        if (lat2 !== 1'b1 || crc_error !== 1'b0 || framing_error !== 1'b1) begin
            failures++;
            $display("FAIL framing_tx: got complete=%b crc=%b frm=%b, want 1 0 1",
                     lat2, crc_error, framing_error);
        end
        drop_enable();
        drive_frame(R7_END, 48, 1'b0, 1'b0, 3);
        checks++;
        if (lat2 !== 1'b1 || crc_error !== 1'b0 || framing_error !== 1'b1) begin
            failures++;
            $display("FAIL framing_end: got complete=%b crc=%b frm=%b, want 1 0 1",
                     lat2, crc_error, framing_error);
        end
        drop_enable();
    endtask

    task automatic test_long();
        logic [135:0] f;
        f = {8'h3F, CID, crc7_ref(CID), 1'b1};
        drive_frame(f, 136, 1'b1, 1'b0, 5);
        checks++;
        if ({early, lat0, lat1, lat2} !== 4'b0001) begin
            failures++;
            $display("FAIL long_latency: got early,l0,l1,l2=%b, want 0001", {early, lat0, lat1, lat2});
        end
        checks++;
        if (response !== f) begin
            failures++;
            $display("FAIL long_response: got %h, want %h", response, f);
        end
        checks++;
        if (crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL long_flags: got crc=%b frm=%b, want 0 0", crc_error, framing_error);
        end
        drop_enable();
    endtask

    task automatic test_abort();
        logic seen;
        @(negedge clock);
        long_response = 1'b0;
        crc_check_disable = 1'b0;
        enable_deserializer = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 47; i >= 28; i--) begin
            cmd_pin = R7[i];
            @(negedge clock);
        end
        enable_deserializer = 1'b0;
        seen = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            cmd_pin = R7[i];
            @(negedge clock);
            if (deserialize_complete) seen = 1'b1;
        end
        cmd_pin = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (deserialize_complete) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL abort: got complete_seen=%b crc=%b frm=%b, want 0 0 0",
                     seen, crc_error, framing_error);
        end
    endtask

    task automatic test_async_reset();
        // Mid-RECEIVE: clears without a clock edge.
        @(negedge clock);
        enable_deserializer = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 47; i >= 28; i--) begin
            cmd_pin = R7[i];
            @(negedge clock);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (deserialize_complete !== 1'b0 || response !== 136'h0 ||
            crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL areset_receive: got complete=%b resp=%h crc=%b frm=%b, want all 0",
                     deserialize_complete, response, crc_error, framing_error);
        end
        enable_deserializer = 1'b0;
        cmd_pin = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        // In DONE with crc_error raised: everything drops immediately.
        drive_frame(R7_BAD, 48, 1'b0, 1'b0, 2);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (deserialize_complete !== 1'b0 || response !== 136'h0 ||
            crc_error !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL areset_done: got complete=%b resp=%h crc=%b frm=%b, want all 0",
                     deserialize_complete, response, crc_error, framing_error);
        end
        enable_deserializer = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_sync_reset();
        drive_frame(R7, 48, 1'b0, 1'b0, 2);
        @(negedge clock);
        reset_deserializer = 1'b1;
        @(negedge clock);
        reset_deserializer = 1'b0;
        checks++;
        if (deserialize_complete !== 1'b0 || response !== 136'h0) begin
            failures++;
            $display("FAIL sreset_done: got complete=%b resp=%h, want 0 0",
                     deserialize_complete, response);
        end
        enable_deserializer = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_hold_rearm();
        logic dropped;
        logic [47:0] junk;
        drive_frame(R7, 48, 1'b0, 1'b0, 2);
        junk = 48'h3CA5_0F0F_1234;
        dropped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cmd_pin = junk[i];
            @(negedge clock);
            if (!deserialize_complete) dropped = 1'b1;
        end
        cmd_pin = 1'b1;
        checks++;
        if (dropped !== 1'b0 || response !== R7) begin
            failures++;
            $display("FAIL hold: got dropped=%b resp=%h, want 0 %h", dropped, response, R7);
        end
        @(negedge clock);
        enable_deserializer = 1'b0;
        drive_frame(R7_TX, 48, 1'b0, 1'b0, 3);
        checks++;
        if (lat2 !== 1'b1 || response !== R7_TX || framing_error !== 1'b1 || crc_error !== 1'b0) begin
            failures++;
            $display("FAIL rearm: got complete=%b resp=%h crc=%b frm=%b, want 1 %h 0 1",
                     lat2, response, crc_error, framing_error, R7_TX);
        end
        drop_enable();
    endtask

    initial begin
        test_reset();
        test_r7();
        test_crc();
        test_framing();
        test_long();
        test_abort();
        test_async_reset();
        test_sync_reset();
        test_hold_rearm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
